// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the sobel pipeline: pulls one IMG_W x IMG_H frame from a
// ready/valid source, tags each pixel with position/border info and waits for the drain.
module sobel_frame_ctrl #(
    parameter int IMG_W     = 64,
    parameter int IMG_H     = 64,
    parameter int CW        = 16,
    parameter int DRAIN_MAX = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          src_valid,
    input  logic [7:0]    src_pixel,
    output logic          src_ready,
    output logic          sob_valid,
    output logic [7:0]    sob_pixel,
    output logic [CW-1:0] sob_col,
    output logic [CW-1:0] sob_row,
    output logic          sob_border,
    input  logic          sob_vout,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int OW   = $clog2(NPIX + 1);
    localparam int DW   = $clog2(DRAIN_MAX + 1);
    localparam logic [OW-1:0] NPIX_C   = OW'(NPIX);
    localparam logic [DW-1:0] DMAX_C   = DW'(DRAIN_MAX);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d, row_q, row_d;
    logic [OW-1:0] out_cnt_q, out_cnt_d;
    logic [DW-1:0] drain_cnt_q, drain_cnt_d;
    logic          sob_valid_q, sob_valid_d;
    logic [7:0]    sob_pixel_q, sob_pixel_d;
    logic [CW-1:0] sob_col_q, sob_col_d, sob_row_q, sob_row_d;
    logic          sob_border_q, sob_border_d;
    logic          err_q, err_d;
    logic          xfer, last_px;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            out_cnt_q    <= '0;
            drain_cnt_q  <= '0;
            sob_valid_q  <= 1'b0;
            sob_pixel_q  <= '0;
            sob_col_q    <= '0;
            sob_row_q    <= '0;
            sob_border_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            out_cnt_q    <= out_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            sob_valid_q  <= sob_valid_d;
            sob_pixel_q  <= sob_pixel_d;
            sob_col_q    <= sob_col_d;
            sob_row_q    <= sob_row_d;
            sob_border_q <= sob_border_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        out_cnt_d    = out_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        sob_valid_d  = 1'b0;
        sob_pixel_d  = sob_pixel_q;
        sob_col_d    = sob_col_q;
        sob_row_d    = sob_row_q;
        sob_border_d = sob_border_q;
        err_d        = err_q;

        xfer    = (state_q == S_RUN) && src_valid;
        last_px = (col_q == COL_LAST) && (row_q == ROW_LAST);

        // Saturating so stray extra pulses cannot wrap the drain comparison.
        if (sob_vout && (state_q == S_RUN || state_q == S_DRAIN) && out_cnt_q != NPIX_C)
            out_cnt_d = out_cnt_q + OW'(1);

        if (xfer) begin
            sob_valid_d  = 1'b1;
            sob_pixel_d  = src_pixel;
            sob_col_d    = col_q;
            sob_row_d    = row_q;
            sob_border_d = (col_q == '0) || (col_q == COL_LAST) ||
                           (row_q == '0) || (row_q == ROW_LAST);
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_RUN;
                    col_d       = '0;
                    row_d       = '0;
                    out_cnt_d   = '0;
                    drain_cnt_d = '0;
                    err_d       = 1'b0;
                end
            end
            S_RUN: begin
                if (xfer && last_px) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            S_DRAIN: begin
                drain_cnt_d = drain_cnt_q + DW'(1);
                // Completion wins over a timeout landing on the same cycle.
                if (out_cnt_d == NPIX_C) begin
                    state_d = S_DONE;
                end else if (drain_cnt_d == DMAX_C) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d     = S_IDLE;
            col_d       = '0;
            row_d       = '0;
            out_cnt_d   = '0;
            drain_cnt_d = '0;
            err_d       = err_q;
        end
    end

    assign src_ready  = (state_q == S_RUN);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;
    assign sob_valid  = sob_valid_q;
    assign sob_pixel  = sob_pixel_q;
    assign sob_col    = sob_col_q;
    assign sob_row    = sob_row_q;
    assign sob_border = sob_border_q;

endmodule
